multi_tick_gen: RTL

//  Parametrised successor to the fixed 1 s / 2 s pulse divider: N_CH independent tick channels.

---
 rtl/multi_tick_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: N_CH independent programmable tick channels with shadowed,
// glitch-free period updates and periodic / one-shot modes.
module multi_tick_gen #(
  parameter int unsigned CLK_FREQ       = 100000000,
  parameter int unsigned N_CH           = 4,
  parameter int unsigned CNT_W          = 34,
  parameter int unsigned DEFAULT_PERIOD = CLK_FREQ,
  localparam int unsigned CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync_clear,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  busy,
  output logic             cfg_err
);

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] per_q [N_CH];
  logic [CNT_W-1:0] per_d [N_CH];
  logic [CNT_W-1:0] shp_q [N_CH];
  logic [CNT_W-1:0] shp_d [N_CH];

  logic [N_CH-1:0] mode_q, mode_d;
  logic [N_CH-1:0] stop_q, stop_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] shm_q, shm_d;
  logic [N_CH-1:0] tick_q, tick_d;
  logic [N_CH-1:0] busy_q, busy_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic            cfg_err_q, cfg_err_d;

  logic            acc;
  logic [N_CH-1:0] wr, pend, run, wrap, apply;

  // Per-channel next state: a shadow is applied only at a wrap or when the
  // channel is not actively counting, so no interval mixes old and new periods.
  always_comb begin
    acc         = cfg_valid & cfg_ready_q;
    cfg_ready_d = 1'b1;
    cfg_err_d   = acc & (32'(cfg_ch) >= N_CH);
    for (int i = 0; i < N_CH; i++) begin
      wr[i]    = acc & (cfg_ch == CH_W'(i));
      shp_d[i] = wr[i] ? cfg_period : shp_q[i];
      shm_d[i] = wr[i] ? cfg_oneshot : shm_q[i];
      pend[i]  = wr[i] | pend_q[i];
      run[i]   = ch_en[i] & (per_q[i] != '0) & ~stop_q[i];
      wrap[i]  = run[i] & (cnt_q[i] == per_q[i] - CNT_W'(1));
      apply[i] = pend[i] & (wrap[i] | ~run[i] | sync_clear);

      cnt_d[i]  = cnt_q[i];
      per_d[i]  = per_q[i];
      mode_d[i] = mode_q[i];
      stop_d[i] = stop_q[i];
      pend_d[i] = pend[i];
      tick_d[i] = 1'b0;

      if (!ch_en[i]) begin
        cnt_d[i]  = '0;
        stop_d[i] = 1'b0;
      end else if (sync_clear) begin
        cnt_d[i] = '0;
      end else if (run[i]) begin
        if (wrap[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          stop_d[i] = mode_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end

      if (apply[i]) begin
        per_d[i]  = shp_d[i];
        mode_d[i] = shm_d[i];
        pend_d[i] = 1'b0;
        stop_d[i] = 1'b0;
      end

      busy_d[i] = ch_en[i] & (per_d[i] != '0) & ~stop_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        per_q[i] <= CNT_W'(DEFAULT_PERIOD);
        shp_q[i] <= CNT_W'(DEFAULT_PERIOD);
      end
      mode_q      <= '0;
      stop_q      <= '0;
      pend_q      <= '0;
      shm_q       <= '0;
      tick_q      <= '0;
      busy_q      <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        per_q[i] <= per_d[i];
        shp_q[i] <= shp_d[i];
      end
      mode_q      <= mode_d;
      stop_q      <= stop_d;
      pend_q      <= pend_d;
      shm_q       <= shm_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign tick      = tick_q;
  assign busy      = busy_q;

endmodule
